fpu_align_unit: RTL and testbench

//  Pre-add alignment stage of the FP adder datapath, feeding the adder ahead of normalisation/mantissa select.

---
 rtl/fpu_pkg.sv | 11 +
 rtl/fpu_align_unit_if.sv | 29 ++
 rtl/sticky_rshift.sv | 15 +
 rtl/fpu_align_unit.sv | 107 ++++++++++
 tb/tb_fpu_align_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, GRS width, align FSM states and counter sizing helper
package fpu_pkg;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MANT_W = 24;
  localparam int GRS_W = 3;
  function automatic int cnt_w(input int mant_w);
    return $clog2(mant_w + 4);
  endfunction
  localparam int CNT_W = cnt_w(DEF_MANT_W);
  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} align_state_e;
endpackage

// File: rtl/fpu_align_unit_if.sv
// fpu_align_unit_if: operand/result handshake bundle of the alignment stage
//   in_valid/in_ready + exp_a/mant_a/exp_b/mant_b  : operand pair
//   out_valid/out_ready + exp_out/mant_big/mant_small/swapped : aligned result
//   master = producer/consumer side, slave = fpu_align_unit
interface fpu_align_unit_if #(
  parameter int EXP_W = fpu_pkg::DEF_EXP_W,
  parameter int MANT_W = fpu_pkg::DEF_MANT_W
);
  logic in_valid;
  logic in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [MANT_W-1:0] mant_a;
  logic [EXP_W-1:0] exp_b;
  logic [MANT_W-1:0] mant_b;
  logic out_valid;
  logic out_ready;
  logic [EXP_W-1:0] exp_out;
  logic [MANT_W-1:0] mant_big;
  logic [MANT_W+fpu_pkg::GRS_W-1:0] mant_small;
  logic swapped;
  modport master (
    output in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
    input in_ready, out_valid, exp_out, mant_big, mant_small, swapped
  );
  modport slave (
    input in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small, swapped
  );
endinterface

// File: rtl/sticky_rshift.sv
// sticky_rshift: right shift by 0..STEP, OR-ing every bit shifted out into the LSB
//   i_d : value, i_k : shift distance, o_d : shifted value with sticky LSB
module sticky_rshift #(
  parameter int W = 27,
  parameter int STEP = 4,
  localparam int KW = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  i_d,
  input  logic [KW-1:0] i_k,
  output logic [W-1:0]  o_d
);
  logic [W-1:0] w_mask;
  assign w_mask = ~({W{1'b1}} << i_k);
  assign o_d = (i_d >> i_k) | {{(W-1){1'b0}}, |(i_d & w_mask)};
endmodule

// File: rtl/fpu_align_unit.sv
// fpu_align_unit: orders two FP operands by magnitude and iteratively aligns the smaller one with G/R/S
//   clk, rst_n : clock, async active-low reset
//   bus        : operand/result handshake (slave side)
module fpu_align_unit
  import fpu_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int STEP = 4
) (
  input logic clk,
  input logic rst_n,
  fpu_align_unit_if.slave bus
);
  localparam int W = MANT_W + GRS_W;
  localparam int CW = cnt_w(MANT_W);
  localparam int KW = $clog2(STEP + 1);
  localparam logic [EXP_W-1:0] D_MAX = EXP_W'(W);
  align_state_e r_state;
  logic [EXP_W-1:0] r_ea, r_eb, r_exp, r_o_exp;
  logic [MANT_W-1:0] r_ma, r_mb, r_big, r_o_big;
  logic [W-1:0] r_ext, r_o_small;
  logic [CW-1:0] r_rem;
  logic r_swap, r_o_swap;
  logic w_b_big, w_direct;
  logic [EXP_W-1:0] w_e_big, w_e_sm, w_d;
  logic [MANT_W-1:0] w_m_big, w_m_sm;
  logic [W-1:0] w_ext0, w_sh;
  logic [KW-1:0] w_k;
  // full tie keeps A as the larger operand
  assign w_b_big = (r_eb > r_ea) || (r_eb == r_ea && r_mb > r_ma);
  assign w_e_big = w_b_big ? r_eb : r_ea;
  assign w_e_sm = w_b_big ? r_ea : r_eb;
  assign w_m_big = w_b_big ? r_mb : r_ma;
  assign w_m_sm = w_b_big ? r_ma : r_mb;
  assign w_d = w_e_big - w_e_sm;
  // shifts past the whole extended mantissa collapse straight to the sticky bit
  assign w_direct = (w_d == '0) || (w_d >= D_MAX);
  assign w_ext0 = (w_d >= D_MAX) ? {{(W-1){1'b0}}, |w_m_sm} : {w_m_sm, {GRS_W{1'b0}}};
  assign w_k = (r_rem < CW'(STEP)) ? r_rem[KW-1:0] : KW'(STEP);
  sticky_rshift #(.W(W), .STEP(STEP)) u_shift (
    .i_d(r_ext),
    .i_k(w_k),
    .o_d(w_sh)
  );
  assign bus.in_ready = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.exp_out = r_o_exp;
  assign bus.mant_big = r_o_big;
  assign bus.mant_small = r_o_small;
  assign bus.swapped = r_o_swap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ea <= '0;
      r_eb <= '0;
      r_ma <= '0;
      r_mb <= '0;
      r_exp <= '0;
      r_big <= '0;
      r_swap <= 1'b0;
      r_ext <= '0;
      r_rem <= '0;
      r_o_exp <= '0;
      r_o_big <= '0;
      r_o_small <= '0;
      r_o_swap <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_ea <= bus.exp_a;
          r_ma <= bus.mant_a;
          r_eb <= bus.exp_b;
          r_mb <= bus.mant_b;
          r_state <= CMP;
        end
        CMP: begin
          r_exp <= w_e_big;
          r_big <= w_m_big;
          r_swap <= w_b_big;
          r_ext <= w_ext0;
          r_rem <= w_d[CW-1:0];
          if (w_direct) begin
            r_o_exp <= w_e_big;
            r_o_big <= w_m_big;
            r_o_swap <= w_b_big;
            r_o_small <= w_ext0;
            r_state <= DONE;
          end else r_state <= SHIFT;
        end
        SHIFT: begin
          r_ext <= w_sh;
          r_rem <= r_rem - CW'(w_k);
          if (r_rem == CW'(w_k)) begin
            r_o_exp <= r_exp;
            r_o_big <= r_big;
            r_o_swap <= r_swap;
            r_o_small <= w_sh;
            r_state <= DONE;
          end
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_align_unit.sv
// tb_fpu_align_unit: vector table + scoreboard check of the alignment stage, STEP=4
module tb_fpu_align_unit;
  typedef struct {
    logic [7:0]  ea;
    logic [23:0] ma;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic [7:0]  eo;
    logic [23:0] big;
    logic [26:0] sm;
    logic        sw;
    int          lat;
    int          t;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit seen = 1'b0;
  vec_t q[$];
  vec_t tab[12];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fpu_align_unit_if #(.EXP_W(8), .MANT_W(24)) bus ();
  fpu_align_unit #(.EXP_W(8), .MANT_W(24), .STEP(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    vec_t v;
    if (bus.out_valid && !seen) begin
      seen = 1'b1;
      if (q.size() != 0) chk("latency", cyc - q[0].t, q[0].lat);
    end
    if (bus.out_valid && bus.out_ready) begin
      seen = 1'b0;
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        v = q.pop_front();
        chk("exp_out", {24'd0, bus.exp_out}, {24'd0, v.eo});
        chk("mant_big", {8'd0, bus.mant_big}, {8'd0, v.big});
        chk("mant_small", {5'd0, bus.mant_small}, {5'd0, v.sm});
        chk("swapped", {31'd0, bus.swapped}, {31'd0, v.sw});
      end
    end
  end
  task automatic send(input vec_t v, input bit track);
    int g = 0;
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 1);
    bus.exp_a = v.ea;
    bus.mant_a = v.ma;
    bus.exp_b = v.eb;
    bus.mant_b = v.mb;
    bus.in_valid = 1'b1;
    v.t = cyc;
    if (track) q.push_back(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || bus.out_valid) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    vec_t h;
    vec_t rv;
    logic [7:0] s_eo;
    logic [23:0] s_big;
    logic [26:0] s_sm;
    logic s_sw;
    int g;
    tab[0]  = '{8'h80, 24'h800000, 8'h80, 24'hC00000, 8'h80, 24'hC00000, 27'h4000000, 1'b1, 2, 0};
    tab[1]  = '{8'h85, 24'h800001, 8'h80, 24'h800001, 8'h85, 24'h800001, 27'h0200001, 1'b0, 4, 0};
    tab[2]  = '{8'h9E, 24'hFFFFFF, 8'h80, 24'h800000, 8'h9E, 24'hFFFFFF, 27'h0000001, 1'b0, 2, 0};
    tab[3]  = '{8'h84, 24'h800000, 8'h80, 24'h80000F, 8'h84, 24'h800000, 27'h0400007, 1'b0, 3, 0};
    tab[4]  = '{8'h7F, 24'hABCDEF, 8'h7F, 24'hABCDEF, 8'h7F, 24'hABCDEF, 27'h55E6F78, 1'b0, 2, 0};
    tab[5]  = '{8'h10, 24'hFFFFFF, 8'h11, 24'h800000, 8'h11, 24'h800000, 27'h3FFFFFC, 1'b1, 3, 0};
    tab[6]  = '{8'h9A, 24'h800000, 8'h80, 24'h800000, 8'h9A, 24'h800000, 27'h0000001, 1'b0, 9, 0};
    tab[7]  = '{8'h9B, 24'h900000, 8'h80, 24'h800000, 8'h9B, 24'h900000, 27'h0000001, 1'b0, 2, 0};
    tab[8]  = '{8'h80, 24'h000000, 8'h9B, 24'h900000, 8'h9B, 24'h900000, 27'h0000000, 1'b1, 2, 0};
    tab[9]  = '{8'h88, 24'hC00000, 8'h80, 24'h123456, 8'h88, 24'hC00000, 27'h00091A3, 1'b0, 4, 0};
    tab[10] = '{8'h01, 24'h800002, 8'h01, 24'h800001, 8'h01, 24'h800002, 27'h4000008, 1'b0, 2, 0};
    tab[11] = '{8'hFF, 24'h800000, 8'h00, 24'hFFFFFF, 8'hFF, 24'h800000, 27'h0000001, 1'b0, 2, 0};
    bus.in_valid = 1'b0;
    bus.exp_a = '0;
    bus.mant_a = '0;
    bus.exp_b = '0;
    bus.mant_b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_exp_out", {24'd0, bus.exp_out}, 0);
    chk("rst_mant_big", {8'd0, bus.mant_big}, 0);
    chk("rst_mant_small", {5'd0, bus.mant_small}, 0);
    chk("rst_swapped", {31'd0, bus.swapped}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) send(tab[i], 1'b1);
    drain();
    bus.out_ready = 1'b0;
    send(tab[0], 1'b1);
    g = 0;
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("hold_reach_done", {31'd0, bus.out_valid}, 1);
    s_eo = bus.exp_out;
    s_big = bus.mant_big;
    s_sm = bus.mant_small;
    s_sw = bus.swapped;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, bus.out_valid}, 1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 0);
      chk("hold_exp_out", {24'd0, bus.exp_out}, {24'd0, s_eo});
      chk("hold_mant_big", {8'd0, bus.mant_big}, {8'd0, s_big});
      chk("hold_mant_small", {5'd0, bus.mant_small}, {5'd0, s_sm});
      chk("hold_swapped", {31'd0, bus.swapped}, {31'd0, s_sw});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_in_ready", {31'd0, bus.in_ready}, 0);
    @(negedge clk);
    chk("post_hs_in_ready", {31'd0, bus.in_ready}, 1);
    send(tab[1], 1'b1);
    drain();
    rv = '{8'h94, 24'h800000, 8'h80, 24'h812345, 8'h0, 24'h0, 27'h0, 1'b0, 0, 0};
    send(rv, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("midrst_mant_big", {8'd0, bus.mant_big}, 0);
    chk("midrst_mant_small", {5'd0, bus.mant_small}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("after_rst_no_out", {31'd0, bus.out_valid}, 0);
    h = tab[1];
    send(h, 1'b1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
